// File: rtl/sign_extend.sv
// Decode-stage immediate generator: picks a field from the instruction word,
// sign-extends it to OUT_W bits and registers the result with a valid flag.
module sign_extend #(
    parameter int IN_W    = 34,
    parameter int OUT_W   = 24,
    parameter int IMM_A_W = 10,
    parameter int IMM_B_W = 16,
    parameter int IMM_C_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  In,
    input  logic [1:0]       ImmSrc,
    input  logic             in_valid,
    output logic [OUT_W-1:0] Imm_Ext,
    output logic             out_valid
);

    logic [OUT_W-1:0] w_imm_a;
    logic [OUT_W-1:0] w_imm_b;
    logic [OUT_W-1:0] w_imm_c;
    logic [OUT_W-1:0] w_imm_sel;
    logic [OUT_W-1:0] r_imm_ext;
    logic             r_out_valid;

    assign w_imm_a = {{(OUT_W-IMM_A_W){In[IMM_A_W-1]}}, In[IMM_A_W-1:0]};
    assign w_imm_b = {{(OUT_W-IMM_B_W){In[IMM_B_W-1]}}, In[IMM_B_W-1:0]};
    assign w_imm_c = {{(OUT_W-IMM_C_W){In[IMM_C_W-1]}}, In[IMM_C_W-1:0]};

    // Format 11 is reserved and yields zero.
    always_comb begin
        w_imm_sel = '0;
        case (ImmSrc)
            2'b00:   w_imm_sel = w_imm_a;
            2'b01:   w_imm_sel = w_imm_b;
            2'b10:   w_imm_sel = w_imm_c;
            default: w_imm_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_imm_ext   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_imm_ext <= w_imm_sel;
            end
        end
    end

    assign Imm_Ext   = r_imm_ext;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sign_extend.sv
// Directed-vector bench for sign_extend: each vector carries a hand-computed
// expected immediate and valid flag, checked one clock after it is applied.
module tb_sign_extend;

    logic        clk;
    logic        rst_n;
    logic [33:0] In;
    logic [1:0]  ImmSrc;
    logic        in_valid;
    logic [23:0] Imm_Ext;
    logic        out_valid;

    int n_tests;
    int n_fail;

    sign_extend dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In        (In),
        .ImmSrc    (ImmSrc),
        .in_valid  (in_valid),
        .Imm_Ext   (Imm_Ext),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
    task automatic apply(input logic rst_v, input logic [33:0] in_v, input logic [1:0] src_v,
                         input logic vld_v, input logic [23:0] exp_imm, input logic exp_vld,
                         input string tag);
        @(negedge clk);
        rst_n    = rst_v;
        In       = in_v;
        ImmSrc   = src_v;
        in_valid = vld_v;
        @(posedge clk);
        #1;
        chk({tag, ".imm"}, {8'h0, Imm_Ext}, {8'h0, exp_imm});
        chk({tag, ".vld"}, {31'h0, out_valid}, {31'h0, exp_vld});
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        In       = 34'h2_DEAD_BEEF;
        ImmSrc   = 2'b01;
        in_valid = 1'b1;
        @(posedge clk);
        apply(1'b0, 34'h1_2345_6789, 2'b00, 1'b1, 24'h000000, 1'b0, "reset");

        apply(1'b1, 34'h0_0000_000C, 2'b00, 1'b1, 24'h00000C, 1'b1, "a_pos");
        apply(1'b1, 34'h0_0000_0200, 2'b00, 1'b1, 24'hFFFE00, 1'b1, "a_neg");
        apply(1'b1, 34'h0_0000_3333, 2'b01, 1'b1, 24'h003333, 1'b1, "b_pos");
        apply(1'b1, 34'h0_0000_8001, 2'b01, 1'b1, 24'hFF8001, 1'b1, "b_neg");
        apply(1'b1, 34'h0_0000_0003, 2'b10, 1'b1, 24'hFFFFFF, 1'b1, "c_neg");
        apply(1'b1, 34'h0_0000_0001, 2'b10, 1'b1, 24'h000001, 1'b1, "c_pos");
        apply(1'b1, 34'h0_0000_000C, 2'b11, 1'b1, 24'h000000, 1'b1, "rsvd");
        apply(1'b1, 34'h3_FFFF_FC00, 2'b00, 1'b1, 24'h000000, 1'b1, "upper_ign");
        apply(1'b1, 34'h2_0000_01FF, 2'b00, 1'b1, 24'h0001FF, 1'b1, "upper_ign2");
        apply(1'b1, 34'h3_FFFF_0123, 2'b01, 1'b1, 24'h000123, 1'b1, "upper_ign3");

        apply(1'b1, 34'h0_0000_03FF, 2'b00, 1'b1, 24'hFFFFFF, 1'b1, "pre_hold");
        apply(1'b1, 34'h0_0000_0005, 2'b01, 1'b0, 24'hFFFFFF, 1'b0, "hold1");
        apply(1'b1, 34'h0_0000_0001, 2'b10, 1'b0, 24'hFFFFFF, 1'b0, "hold2");

        apply(1'b1, 34'h0_0000_0155, 2'b00, 1'b1, 24'h000155, 1'b1, "pre_rst");
        apply(1'b0, 34'h0_0000_0155, 2'b00, 1'b1, 24'h000000, 1'b0, "mid_rst");
        apply(1'b1, 34'h0_0000_02AA, 2'b00, 1'b1, 24'hFFFEAA, 1'b1, "post_rst");

        // Inputs changed mid-cycle must not reach the outputs before the edge.
        @(negedge clk);
        In       = 34'h0_0000_000C;
        ImmSrc   = 2'b00;
        in_valid = 1'b0;
        #1;
        chk("no_comb.imm", {8'h0, Imm_Ext}, 32'h00FFFEAA);
        chk("no_comb.vld", {31'h0, out_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
